math_engine: RTL and testbench
==============================

// Module: math_engine
// PURPOSE
//  Sequential math coprocessor on the far side of the CSR file's math taps. Watches MATH_CTRL, latches
//  MATH_OPA/OPB/OPC on START and iterates one step per clock. Returns results and status through the
//  CSR file's auxiliary write port (w2). One CSR write per cycle at most; CPU reads results by CSR polling.
// PARAMETERS
//  P_DW   24  data width (= `HBIT_DATA+1); ops and results sized from it
//  P_AW    8  CSR index width (= `HBIT_TGT_CSR+1)
// PORTS
//  iw_clk          in   1     clock
//  iw_rst_n        in   1     reset, asynchronous, active-low
//  iw_math_ctrl    in   P_DW  MATH_CTRL tap: [0]START [4:1]OP [8]BUSY [9]DONE [10]ERR
//  iw_math_opa     in   P_DW  operand A tap
//  iw_math_opb     in   P_DW  operand B tap
//  iw_math_opc     in   P_DW  operand C tap (addend for MADDU)
//  ow_w2_enable    out  1     aux CSR write strobe
//  ow_w2_addr      out  P_AW  aux CSR index (CTRL, RES0, RES1 only)
//  ow_w2_data      out  P_DW  aux CSR write data
//  ow_busy         out  1     FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, all datapath regs 0, ow_w2_enable=0, ow_w2_addr=0, ow_w2_data=0, ow_busy=0.
//  Reset mid-operation aborts at once; no further w2 writes are issued.
//  All outputs come from flops. ow_w2_* are valid for exactly the cycle spent in a write state.
//  FSM: IDLE -> ACK -> RUN -> WR0 -> WR1 -> WRC -> IDLE.
//   IDLE: leaves when ctrl[0]=1 && ctrl[8]=0; latches OP, OPA, OPB, OPC.
//   ACK : writes CTRL = {OP, BUSY=1, START=0, DONE=0, ERR=0}; goes to RUN.
//         DIVU with OPB=0 or an illegal OP skips RUN and goes to WR0.
//   RUN : one step per cycle with an iteration counter.
//         MULU/MADDU: 24 cycles of shift-add.
//         DIVU: 24 cycles of restoring division.
//   WR0 : writes RES0. WR1: writes RES1. WRC: writes CTRL = {OP, DONE=1, ERR, BUSY=0, START=0}.
//  Timing (START seen in cycle 0): ACK=1, RUN=2..25, WR0=26, WR1=27, WRC=28; DONE readable from cycle 29.
//  Results:
//   OP0 MULU : {RES1,RES0} = A*B, 48-bit.
//   OP1 DIVU : RES0 = A/B, RES1 = A%B.
//   OP2 MADDU: {RES1,RES0} = A*B + zext(C), mod 2^48.
//  DIVU by zero: RES0 = all-ones, RES1 = A, ERR=1.
//  Illegal OP: RES0 = RES1 = 0, ERR=1.
//  Ctrl/operand CSR changes after IDLE are ignored. A START written while busy is lost, because WRC
//   overwrites CTRL; software polls BUSY/DONE before issuing.
//  START held at 1 after WRC does not retrigger: WRC clears it.
//  Same-cycle CPU write to CTRL: the CSR file resolves it (w2 wins). The engine makes no retry.
// CONFIGURATION
//  MATH_SQRT_EN defined: OP3 ISQRT, 12 RUN cycles (WRC at cycle 16). RES0 = floor(sqrt(A)), RES1 = A - RES0^2.
//  MATH_SQRT_EN undefined: OP3 is illegal (ERR=1, no RUN). No sqrt logic is synthesised.
// STRUCTURE
//  Add to the shared header csr.vh: CSR_IDX_MATH_RES0, CSR_IDX_MATH_RES1.
//  Add to the shared header math.vh:
//   ctrl bit positions MATH_CTRL_START/OP_LO/OP_HI/BUSY/DONE/ERR
//   op codes MATH_OP_MULU/DIVU/MADDU/ISQRT
//   FSM state encodings
//  One sub-module, math_step_core: combinational single-iteration step (shift-add, restoring-divide,
//   sqrt digit). Selected by OP, it takes the accumulator/partial regs and returns their next values.
//   math_engine owns the FSM, counter and registers.
// TESTING
//  1 MULU A=0x000123 B=0x000456, START -> CTRL BUSY write at cycle 1; RES0=0x04EDC2, RES1=0 at cycles
//    26/27; CTRL DONE=1 ERR=0 at cycle 28.
//  2 DIVU A=1000 B=7 -> RES0=142, RES1=6, DONE=1, ERR=0.
//    DIVU A=5 B=0 -> RES0=0xFFFFFF, RES1=5, ERR=1, WRC at cycle 4.
//  3 MADDU A=B=0xFFFFFF C=0xFFFFFF -> {RES1,RES0}=0xFFFFFF000000, ERR=0.
//  4 OP=3, A=1000: with MATH_SQRT_EN -> RES0=31, RES1=39, WRC at cycle 16; without -> ERR=1, WRC at cycle 4.
//  5 iw_rst_n low at cycle 10 of a MULU -> outputs 0 same cycle, no w2 pulse after release.
//    Then a new START completes correctly.
//  6 START re-asserted and operands changed during RUN -> original result written, DONE=1,
//    exactly 4 w2 pulses total.

Source files
------------

// File: rtl/math_engine_pkg.sv
// math_engine_pkg: shared constants for the math coprocessor.
//   Holds the CSR indices, the MATH_CTRL bit positions, the op codes, the FSM state encodings
//   and a helper that packs the MATH_CTRL status word.
//   The optional ISQRT op is enabled by defining MATH_SQRT_EN.
package math_engine_pkg;

   localparam int unsigned MATH_DW = 24;   // data width
   localparam int unsigned MATH_AW = 8;    // CSR index width

   // CSR indices reachable through the auxiliary write port
   localparam int unsigned CSR_IDX_MATH_CTRL = 32'h40;
   localparam int unsigned CSR_IDX_MATH_RES0 = 32'h41;
   localparam int unsigned CSR_IDX_MATH_RES1 = 32'h42;

   // MATH_CTRL bit positions
   localparam int unsigned MATH_CTRL_START = 0;
   localparam int unsigned MATH_CTRL_OP_LO = 1;
   localparam int unsigned MATH_CTRL_OP_HI = 4;
   localparam int unsigned MATH_CTRL_BUSY  = 8;
   localparam int unsigned MATH_CTRL_DONE  = 9;
   localparam int unsigned MATH_CTRL_ERR   = 10;

   // op codes
   localparam logic [3:0] MATH_OP_MULU  = 4'd0;
   localparam logic [3:0] MATH_OP_DIVU  = 4'd1;
   localparam logic [3:0] MATH_OP_MADDU = 4'd2;
   localparam logic [3:0] MATH_OP_ISQRT = 4'd3;

   // iteration counts
   localparam int unsigned MATH_RUN_MUL  = 24;
   localparam int unsigned MATH_RUN_SQRT = 12;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ACK  = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_WR0  = 3'd3;
   localparam logic [2:0] ST_WR1  = 3'd4;
   localparam logic [2:0] ST_WRC  = 3'd5;

   // MATH_CTRL status word; START is always written back as 0
   function automatic logic [10:0] ctrl_word(input logic [3:0] op, input logic busy,
                                             input logic done, input logic err);
      return {err, done, busy, 3'b000, op, 1'b0};
   endfunction

endpackage

// File: rtl/math_engine_if.sv
// math_engine_if: CSR-file taps into the math engine and its auxiliary write port back.
//   master: CSR file side (drives taps, receives w2 writes)
//   slave : math engine side
interface math_engine_if
   import math_engine_pkg::*;
#(
   parameter int unsigned P_DW = MATH_DW,
   parameter int unsigned P_AW = MATH_AW
);
   logic [P_DW-1:0] iw_math_ctrl;
   logic [P_DW-1:0] iw_math_opa;
   logic [P_DW-1:0] iw_math_opb;
   logic [P_DW-1:0] iw_math_opc;
   logic            ow_w2_enable;
   logic [P_AW-1:0] ow_w2_addr;
   logic [P_DW-1:0] ow_w2_data;
   logic            ow_busy;

   modport master (
      output iw_math_ctrl, iw_math_opa, iw_math_opb, iw_math_opc,
      input  ow_w2_enable, ow_w2_addr, ow_w2_data, ow_busy
   );

   modport slave (
      input  iw_math_ctrl, iw_math_opa, iw_math_opb, iw_math_opc,
      output ow_w2_enable, ow_w2_addr, ow_w2_data, ow_busy
   );
endinterface

// File: rtl/math_step_core.sv
// math_step_core: one combinational iteration of the selected op.
//   op        : op code selecting the step kind
//   hi/lo/aux : current accumulator (hi), partial/quotient (lo), operand or root (aux)
//   *_nx_c    : next values of the same registers
//   MULU/MADDU: right-shifting shift-add, {hi,lo} ends as A*B (+C preloaded in hi).
//   DIVU      : restoring division, lo ends as quotient, hi as remainder.
//   ISQRT     : (MATH_SQRT_EN only) two radicand bits per step, aux ends as root, hi as remainder.
module math_step_core
   import math_engine_pkg::*;
#(
   parameter int unsigned P_DW = MATH_DW
) (
   input  logic [3:0]      op,
   input  logic [P_DW-1:0] hi,
   input  logic [P_DW-1:0] lo,
   input  logic [P_DW-1:0] aux,
   output logic [P_DW-1:0] hi_nx_c,
   output logic [P_DW-1:0] lo_nx_c,
   output logic [P_DW-1:0] aux_nx_c
);

   logic [P_DW:0]   sum;
   logic [P_DW:0]   sh;
   logic [P_DW-1:0] diff;
`ifdef MATH_SQRT_EN
   logic [P_DW-1:0] rem;
   logic [P_DW-1:0] trial;
`endif

   always_comb begin
      hi_nx_c  = hi;
      lo_nx_c  = lo;
      aux_nx_c = aux;
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, aux} : '0);
      sh       = {hi, lo[P_DW-1]};
      diff     = sh[P_DW-1:0] - aux;
`ifdef MATH_SQRT_EN
      rem      = {hi[P_DW-3:0], lo[P_DW-1:P_DW-2]};
      trial    = {aux[P_DW-3:0], 2'b01};
`endif
      case (op)
         MATH_OP_MULU, MATH_OP_MADDU: begin
            // carry of the add drops into hi's msb as the pair shifts right
            hi_nx_c = sum[P_DW:1];
            lo_nx_c = {sum[0], lo[P_DW-1:1]};
         end
         MATH_OP_DIVU: begin
            if (sh >= {1'b0, aux}) begin
               hi_nx_c = diff;
               lo_nx_c = {lo[P_DW-2:0], 1'b1};
            end else begin
               hi_nx_c = sh[P_DW-1:0];
               lo_nx_c = {lo[P_DW-2:0], 1'b0};
            end
         end
`ifdef MATH_SQRT_EN
         MATH_OP_ISQRT: begin
            lo_nx_c = {lo[P_DW-3:0], 2'b00};
            if (rem >= trial) begin
               hi_nx_c  = rem - trial;
               aux_nx_c = {aux[P_DW-2:0], 1'b1};
            end else begin
               hi_nx_c  = rem;
               aux_nx_c = {aux[P_DW-2:0], 1'b0};
            end
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/math_engine.sv
// math_engine: sequential math coprocessor behind the CSR file's math taps.
//   iw_clk, iw_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : MATH_CTRL/OPA/OPB/OPC taps in; w2 write strobe/index/data and busy out
//   Latches operands on START, iterates one step per clock, then writes RES0, RES1 and CTRL
//   back through w2. Define MATH_SQRT_EN to add OP3 ISQRT; otherwise OP3 is illegal.
//   P_DW/P_AW must match the connected interface instance.
module math_engine
   import math_engine_pkg::*;
#(
   parameter int unsigned P_DW = MATH_DW,
   parameter int unsigned P_AW = MATH_AW
) (
   input  logic        iw_clk,
   input  logic        iw_rst_n,
   math_engine_if.slave bus
);

   logic [2:0]      state_q, state_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [3:0]      op_q, op_d;
   logic            err_q, err_d;
   logic [P_DW-1:0] hi_q, hi_d, lo_q, lo_d, aux_q, aux_d;
   logic            w2_en_q, w2_en_d;
   logic [P_AW-1:0] w2_addr_q, w2_addr_d;
   logic [P_DW-1:0] w2_data_q, w2_data_d;
   logic            busy_q;

   logic [P_DW-1:0] step_hi_c, step_lo_c, step_aux_c;
   logic [P_DW-1:0] res0_run_c;
   logic [4:0]      last_c;
   logic [3:0]      op_in_c;
   logic            start_c;
   logic            unused_ctrl_bits;

   assign op_in_c = bus.iw_math_ctrl[MATH_CTRL_OP_HI:MATH_CTRL_OP_LO];
   assign start_c = bus.iw_math_ctrl[MATH_CTRL_START] & ~bus.iw_math_ctrl[MATH_CTRL_BUSY];
   assign unused_ctrl_bits = ^{bus.iw_math_ctrl[P_DW-1:MATH_CTRL_DONE], bus.iw_math_ctrl[7:5]};

   math_step_core #(.P_DW(P_DW)) u_step (
      .op       (op_q),
      .hi       (hi_q),
      .lo       (lo_q),
      .aux      (aux_q),
      .hi_nx_c  (step_hi_c),
      .lo_nx_c  (step_lo_c),
      .aux_nx_c (step_aux_c)
   );

   // iteration count and RES0 source depend on the latched op
   always_comb begin
      last_c     = 5'(MATH_RUN_MUL - 1);
      res0_run_c = step_lo_c;
`ifdef MATH_SQRT_EN
      if (op_q == MATH_OP_ISQRT) begin
         last_c     = 5'(MATH_RUN_SQRT - 1);
         res0_run_c = step_aux_c;
      end
`endif
   end

   // next-state, datapath and next-output logic; outputs are registered from the state being entered
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      err_d     = err_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      aux_d     = aux_q;
      w2_en_d   = 1'b0;
      w2_addr_d = '0;
      w2_data_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d = ST_ACK;
               op_d    = op_in_c;
               cnt_d   = '0;
               err_d   = 1'b0;
               hi_d    = '0;
               lo_d    = bus.iw_math_opa;
               aux_d   = '0;
               case (op_in_c)
                  MATH_OP_MULU: begin
                     lo_d  = bus.iw_math_opb;
                     aux_d = bus.iw_math_opa;
                  end
                  MATH_OP_MADDU: begin
                     hi_d  = bus.iw_math_opc;
                     lo_d  = bus.iw_math_opb;
                     aux_d = bus.iw_math_opa;
                  end
                  MATH_OP_DIVU: begin
                     if (bus.iw_math_opb == '0) begin
                        // divide by zero: results preloaded, RUN skipped
                        hi_d  = bus.iw_math_opa;
                        lo_d  = '1;
                        err_d = 1'b1;
                     end else begin
                        aux_d = bus.iw_math_opb;
                     end
                  end
`ifdef MATH_SQRT_EN
                  MATH_OP_ISQRT: begin
                  end
`endif
                  default: begin
                     lo_d  = '0;
                     err_d = 1'b1;
                  end
               endcase
               w2_en_d   = 1'b1;
               w2_addr_d = P_AW'(CSR_IDX_MATH_CTRL);
               w2_data_d = P_DW'(ctrl_word(op_in_c, 1'b1, 1'b0, 1'b0));
            end
         end
         ST_ACK: begin
            if (err_q) begin
               state_d   = ST_WR0;
               w2_en_d   = 1'b1;
               w2_addr_d = P_AW'(CSR_IDX_MATH_RES0);
               w2_data_d = lo_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            hi_d  = step_hi_c;
            lo_d  = step_lo_c;
            aux_d = step_aux_c;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == last_c) begin
               state_d   = ST_WR0;
               w2_en_d   = 1'b1;
               w2_addr_d = P_AW'(CSR_IDX_MATH_RES0);
               w2_data_d = res0_run_c;
            end
         end
         ST_WR0: begin
            state_d   = ST_WR1;
            w2_en_d   = 1'b1;
            w2_addr_d = P_AW'(CSR_IDX_MATH_RES1);
            w2_data_d = hi_q;
         end
         ST_WR1: begin
            state_d   = ST_WRC;
            w2_en_d   = 1'b1;
            w2_addr_d = P_AW'(CSR_IDX_MATH_CTRL);
            w2_data_d = P_DW'(ctrl_word(op_q, 1'b0, 1'b1, err_q));
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state, datapath and output registers
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         err_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         aux_q     <= '0;
         w2_en_q   <= 1'b0;
         w2_addr_q <= '0;
         w2_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         err_q     <= err_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         aux_q     <= aux_d;
         w2_en_q   <= w2_en_d;
         w2_addr_q <= w2_addr_d;
         w2_data_q <= w2_data_d;
         busy_q    <= (state_d != ST_IDLE);
      end
   end

   assign bus.ow_w2_enable = w2_en_q;
   assign bus.ow_w2_addr   = w2_addr_q;
   assign bus.ow_w2_data   = w2_data_q;
   assign bus.ow_busy      = busy_q;

endmodule

// File: tb/tb_math_engine.sv
// tb_math_engine: directed bench for math_engine with a minimal CSR-file CTRL model.
//   w2 writes to CTRL win over same-cycle CPU writes. Pulse timing is relative to cycle 0,
//   the first cycle in which START is visible on the CTRL tap.
module tb_math_engine;
   import math_engine_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   math_engine_if bus ();

   math_engine dut (
      .iw_clk   (clk),
      .iw_rst_n (rst_n),
      .bus      (bus.slave)
   );

   logic [23:0] csr_ctrl = '0;
   logic        cpu_we   = 1'b0;
   logic        cpu_mark = 1'b0;
   logic [23:0] cpu_data = '0;
   int          cyc      = 0;
   int          t0       = 0;

   int          checks   = 0;
   int          errors   = 0;
   int          np;
   int          p_rel  [8];
   logic [7:0]  p_addr [8];
   logic [23:0] p_data [8];

   assign bus.iw_math_ctrl = csr_ctrl;

   // CTRL register of the CSR file
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.ow_w2_enable && bus.ow_w2_addr == 8'(CSR_IDX_MATH_CTRL)) begin
         csr_ctrl <= bus.ow_w2_data;
      end else if (cpu_we) begin
         csr_ctrl <= cpu_data;
         if (cpu_mark) t0 <= cyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c);
      @(negedge clk);
      bus.iw_math_opa = a;
      bus.iw_math_opb = b;
      bus.iw_math_opc = c;
      cpu_data = {19'd0, op, 1'b1};
      cpu_mark = 1'b1;
      cpu_we   = 1'b1;
   endtask

   // record w2 pulses for ncyc cycles; at relative cycle inj the CPU rewrites START and operands
   task automatic collect(input int ncyc, input int inj);
      np = 0;
      repeat (ncyc) begin
         @(negedge clk);
         cpu_we = 1'b0;
         if (bus.ow_w2_enable) begin
            if (np < 8) begin
               p_rel[np]  = cyc - t0;
               p_addr[np] = bus.ow_w2_addr;
               p_data[np] = bus.ow_w2_data;
            end
            np++;
         end
         if (cyc - t0 == inj) begin
            bus.iw_math_opa = 24'h000777;
            bus.iw_math_opb = 24'h000003;
            bus.iw_math_opc = 24'h000009;
            cpu_data = 24'h000005;
            cpu_mark = 1'b0;
            cpu_we   = 1'b1;
         end
      end
   endtask

   task automatic chk_pulse(input string tag, input int k, input int rel, input int unsigned addr,
                            input logic [23:0] data);
      chk(tag, {8'd0, 8'(p_rel[k]), p_addr[k], p_data[k]}, {8'd0, 8'(rel), 8'(addr), data});
   endtask

   task automatic chk_op(input string tag, input logic [23:0] ack, input int r0_rel,
                         input logic [23:0] res0, input logic [23:0] res1, input logic [23:0] wrc);
      chk({tag, "_npulse"}, 48'(np), 48'd4);
      chk_pulse({tag, "_ack"},  0, 1,          CSR_IDX_MATH_CTRL, ack);
      chk_pulse({tag, "_res0"}, 1, r0_rel,     CSR_IDX_MATH_RES0, res0);
      chk_pulse({tag, "_res1"}, 2, r0_rel + 1, CSR_IDX_MATH_RES1, res1);
      chk_pulse({tag, "_wrc"},  3, r0_rel + 2, CSR_IDX_MATH_CTRL, wrc);
      chk({tag, "_idle"}, 48'(bus.ow_busy), 48'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_en"},   48'(bus.ow_w2_enable), 48'd0);
      chk({tag, "_addr"}, 48'(bus.ow_w2_addr),   48'd0);
      chk({tag, "_data"}, 48'(bus.ow_w2_data),   48'd0);
      chk({tag, "_busy"}, 48'(bus.ow_busy),      48'd0);
   endtask

   initial begin
      bus.iw_math_opa = '0;
      bus.iw_math_opb = '0;
      bus.iw_math_opc = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      start_op(4'd0, 24'h000123, 24'h000456, 24'h0);
      collect(40, -1);
      chk_op("mulu", 24'h000100, 26, 24'h04EDC2, 24'h000000, 24'h000200);

      start_op(4'd1, 24'd1000, 24'd7, 24'h0);
      collect(40, -1);
      chk_op("divu", 24'h000102, 26, 24'h00008E, 24'h000006, 24'h000202);

      start_op(4'd1, 24'd5, 24'd0, 24'h0);
      collect(40, -1);
      chk_op("div0", 24'h000102, 2, 24'hFFFFFF, 24'h000005, 24'h000602);

      start_op(4'd2, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
      collect(40, -1);
      chk_op("maddu", 24'h000104, 26, 24'h000000, 24'hFFFFFF, 24'h000204);

      start_op(4'd3, 24'd1000, 24'd0, 24'h0);
      collect(40, -1);
`ifdef MATH_SQRT_EN
      chk_op("isqrt", 24'h000106, 14, 24'h00001F, 24'h000027, 24'h000206);
`else
      chk_op("op3", 24'h000106, 2, 24'h000000, 24'h000000, 24'h000606);
`endif

      start_op(4'd15, 24'd1, 24'd1, 24'd1);
      collect(40, -1);
      chk_op("illegal", 24'h00011E, 2, 24'h000000, 24'h000000, 24'h00061E);

      // reset in the middle of a MULU
      start_op(4'd0, 24'h000123, 24'h000456, 24'h0);
      collect(11, -1);
      chk("rst_pre_npulse", 48'(np), 48'd1);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("rst_mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      collect(40, -1);
      chk("rst_post_npulse", 48'(np), 48'd0);

      start_op(4'd0, 24'h000123, 24'h000456, 24'h0);
      collect(40, -1);
      chk_op("after_rst", 24'h000100, 26, 24'h04EDC2, 24'h000000, 24'h000200);

      // START and operands rewritten during RUN are ignored
      start_op(4'd0, 24'h000123, 24'h000456, 24'h0);
      collect(40, 10);
      chk_op("restart", 24'h000100, 26, 24'h04EDC2, 24'h000000, 24'h000200);
      chk("restart_ctrl", 48'(csr_ctrl), 48'h000200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
